// File: rtl/tristate_pad_serializer.sv
// tristate_pad_serializer
// Upstream driver for a tri-state pad buffer on a shared half-duplex line.
// Each accepted word is sent LSB first, CLK_DIV clocks per bit, framed by
// TURN_CYC guard cycles at IDLE_LVL before and after the burst.
// pad_o / pad_t come straight from flops and follow the state by one cycle.
// Optional feature macro: PARITY_EN appends an even-parity bit after the MSB.
// rst_n asserts asynchronously; its release is expected to be synchronous to clk.
module tristate_pad_serializer #(
  parameter int   DATA_W   = 8,
  parameter int   CLK_DIV  = 4,
  parameter int   TURN_CYC = 2,
  parameter logic IDLE_LVL = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              pad_o,
  output logic              pad_t,
  output logic              busy
);

`ifdef PARITY_EN
  localparam int SR_W = DATA_W + 1;
`else
  localparam int SR_W = DATA_W;
`endif
  localparam int CNT_MAX = (CLK_DIV > TURN_CYC) ? CLK_DIV : TURN_CYC;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int BIT_W   = (SR_W > 1) ? $clog2(SR_W) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LEAD  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_TRAIL = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [SR_W-1:0]  shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             pad_o_q, pad_o_d;
  logic             pad_t_q, pad_t_d;
  logic             ready_en_q;
  logic [SR_W-1:0]  load_word;
  logic             div_last, bit_last, turn_last, accept;

  // The parity bit rides at the top of the shift register so it leaves after the MSB.
`ifdef PARITY_EN
  assign load_word = {^s_data, s_data};
`else
  assign load_word = s_data;
`endif

  assign div_last  = (cnt_q == CNT_W'(CLK_DIV - 1));
  assign turn_last = (cnt_q == CNT_W'(TURN_CYC - 1));
  assign bit_last  = (bit_q == BIT_W'(SR_W - 1));

  // Ready in IDLE, or in the final cycle of the final bit for a gap-free reload.
  assign s_ready = ready_en_q &&
                   ((state_q == ST_IDLE) || ((state_q == ST_SHIFT) && div_last && bit_last));
  assign accept  = s_valid && s_ready;
  assign busy    = (state_q != ST_IDLE);
  assign pad_o   = pad_o_q;
  assign pad_t   = pad_t_q;

  // Pad values for the cycle after this one, decoded from the current state.
  assign pad_t_d = (state_q == ST_IDLE);
  assign pad_o_d = (state_q == ST_SHIFT) ? shreg_q[0] : IDLE_LVL;

  // Next-state, counter and shift-register update.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no latch can be inferred.
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          shreg_d = load_word;
          cnt_d   = '0;
          bit_d   = '0;
          state_d = (TURN_CYC == 0) ? ST_SHIFT : ST_LEAD;
        end
      end
      ST_LEAD: begin
        if (turn_last) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_SHIFT: begin
        if (!div_last) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = '0;
          if (!bit_last) begin
            bit_d   = bit_q + BIT_W'(1);
            shreg_d = shreg_q >> 1;
          end else begin
            bit_d = '0;
            if (accept) begin
              // Back-to-back word: stay in SHIFT, line remains driven.
              shreg_d = load_word;
            end else begin
              state_d = (TURN_CYC == 0) ? ST_IDLE : ST_TRAIL;
            end
          end
        end
      end
      ST_TRAIL: begin
        if (turn_last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        bit_d   = '0;
      end
    endcase
  end

  // State, datapath and pad flops; reset releases the line immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      // NOTE: the shift register is reset too; it is tiny and never carries X afterwards.
      shreg_q    <= '0;
      cnt_q      <= '0;
      bit_q      <= '0;
      pad_o_q    <= IDLE_LVL;
      pad_t_q    <= 1'b1;
      ready_en_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      pad_o_q    <= pad_o_d;
      pad_t_q    <= pad_t_d;
      ready_en_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tristate_pad_serializer.sv
// Bench for tristate_pad_serializer: instance A uses the default parameters and
// is checked every cycle against a line-timeline model; instance B
// (DATA_W=4, CLK_DIV=1, TURN_CYC=0) is checked against hand-computed values.
// Honours PARITY_EN the same way as the design.
module tb_tristate_pad_serializer;

  localparam int   DATA_W   = 8;
  localparam int   CLK_DIV  = 4;
  localparam int   TURN_CYC = 2;
  localparam logic IDLE_LVL = 1'b1;
`ifdef PARITY_EN
  localparam int PAR = 1;
  localparam logic [127:0] A5_PAT  = {88'd0, 40'b11_1111_0000_1111_0000_0000_1111_0000_1111_0000_11};
  localparam logic [127:0] B2B_PAT = {52'd0, 2'b11, 4'hF, 28'h0, 4'hF, 32'hFFFF_FFFF, 4'h0, 2'b11};
  localparam logic [127:0] B_PAT   = {123'd0, 5'b01100};
`else
  localparam int PAR = 0;
  localparam logic [127:0] A5_PAT  = {92'd0, 36'b11_1111_0000_1111_0000_0000_1111_0000_1111_11};
  localparam logic [127:0] B2B_PAT = {60'd0, 2'b11, 4'hF, 28'h0, 32'hFFFF_FFFF, 2'b11};
  localparam logic [127:0] B_PAT   = {124'd0, 4'b0110};
`endif
  localparam int A_LAST  = TURN_CYC + (DATA_W + PAR) * CLK_DIV;  // accept-to-last-bit distance
  localparam int A5_LEN  = 2 * TURN_CYC + (DATA_W + PAR) * CLK_DIV;
  localparam int B2B_LEN = 2 * TURN_CYC + 2 * (DATA_W + PAR) * CLK_DIV;
  localparam int B_BITS  = 4 + PAR;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b1;
  logic [DATA_W-1:0] s_data_a  = '0;
  logic              s_valid_a = 1'b0;
  logic              s_ready_a, pad_o_a, pad_t_a, busy_a;
  logic [3:0]        s_data_b  = '0;
  logic              s_valid_b = 1'b0;
  logic              s_ready_b, pad_o_b, pad_t_b, busy_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  tristate_pad_serializer #(
    .DATA_W(DATA_W), .CLK_DIV(CLK_DIV), .TURN_CYC(TURN_CYC), .IDLE_LVL(IDLE_LVL)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .s_data(s_data_a), .s_valid(s_valid_a),
    .s_ready(s_ready_a), .pad_o(pad_o_a), .pad_t(pad_t_a), .busy(busy_a)
  );

  tristate_pad_serializer #(
    .DATA_W(4), .CLK_DIV(1), .TURN_CYC(0), .IDLE_LVL(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .s_data(s_data_b), .s_valid(s_valid_b),
    .s_ready(s_ready_b), .pad_o(pad_o_b), .pad_t(pad_t_b), .busy(busy_b)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model of instance A ----------------
  // The model keeps a queue of the line cycles still to come for the current
  // burst(s): each entry is the level on the line for one clock, with the final
  // data cycle flagged (that cycle is the only non-idle one that may accept).
  typedef struct packed { logic o; logic last; } line_t;
  line_t lq[$];
  logic  m_live = 1'b0;
  logic  exp_t  = 1'b1;
  logic  exp_o  = IDLE_LVL;

  task automatic m_push(input logic o, input int n);
    line_t e;
    e.o = o;
    e.last = 1'b0;
    for (int k = 0; k < n; k++) lq.push_back(e);
  endtask

  task automatic m_burst(input logic [DATA_W-1:0] w, input logic from_idle);
    line_t e;
    if (from_idle) m_push(IDLE_LVL, TURN_CYC);
    for (int b = 0; b < DATA_W; b++) m_push(w[b], CLK_DIV);
`ifdef PARITY_EN
    m_push(^w, CLK_DIV);
`endif
    e = lq.pop_back();
    e.last = 1'b1;
    lq.push_back(e);
    m_push(IDLE_LVL, TURN_CYC);
  endtask

  function automatic logic m_ready();
    return m_live && ((lq.size() == 0) || lq[0].last);
  endfunction

  // Advance the model one clock: the pads show the line level of the cycle just ended.
  always @(posedge clk or negedge rst_n) begin : model
    logic rdy, was_empty;
    if (!rst_n) begin
      lq.delete();
      m_live = 1'b0;
      exp_t  = 1'b1;
      exp_o  = IDLE_LVL;
    end else begin
      was_empty = (lq.size() == 0);
      rdy = m_ready();
      if (was_empty) begin
        exp_t = 1'b1;
        exp_o = IDLE_LVL;
      end else begin
        exp_t = 1'b0;
        exp_o = lq[0].o;
        void'(lq.pop_front());
      end
      if (s_valid_a && rdy) begin
        lq.delete();  // only trailing guard cycles can remain; a reload drops them
        m_burst(s_data_a, was_empty);
      end
      m_live = 1'b1;
    end
  end

  // Compare instance A with the model on every falling edge.
  always @(negedge clk) begin
    check("A pad_t", pad_t_a, exp_t);
    check("A pad_o", pad_o_a, exp_o);
    check("A s_ready", s_ready_a, m_ready());
    check("A busy", busy_a, lq.size() != 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    int cnt, acc2;
    logic [127:0] rec;

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset s_ready", s_ready_a, 1'b0);
    check("reset pad_t", pad_t_a, 1'b1);
    check("reset pad_o", pad_o_a, IDLE_LVL);
    check("reset busy B", busy_b, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("post-reset s_ready", s_ready_a, 1'b1);
    check("post-reset busy", busy_a, 1'b0);

    // Single word 8'hA5, with s_valid poked during LEAD, mid-SHIFT and TRAIL
    s_data_a = 8'hA5;
    s_valid_a = 1'b1;
    cnt = 0;
    rec = '0;
    for (int i = 1; i <= 45; i++) begin
      @(negedge clk);
      if (pad_t_a == 1'b0) begin
        cnt++;
        rec = {rec[126:0], pad_o_a};
      end
      s_valid_a = (i == 1) || (i == 10) || (i == A_LAST + 1);
      s_data_a  = 8'h3C ^ 8'(i);
    end
    check("A5 burst length", cnt, A5_LEN);
    check("A5 bit pattern", rec, A5_PAT);
    check("A5 released pad_t", pad_t_a, 1'b1);
    check("A5 ready after", s_ready_a, 1'b1);

    // Back-to-back 8'h01 then 8'hFF, s_valid held until the second accept
    s_data_a = 8'h01;
    s_valid_a = 1'b1;
    cnt = 0;
    rec = '0;
    acc2 = -1;
    for (int i = 1; i <= 90; i++) begin
      @(negedge clk);
      if (pad_t_a == 1'b0) begin
        cnt++;
        rec = {rec[126:0], pad_o_a};
      end
      if (acc2 >= 0) s_valid_a = 1'b0;
      else if (s_valid_a && s_ready_a) acc2 = i;
      s_data_a = 8'hFF;
    end
    s_valid_a = 1'b0;
    check("b2b second accept cycle", acc2, A_LAST);
    check("b2b line-driven length", cnt, B2B_LEN);
    check("b2b bit pattern", rec, B2B_PAT);

`ifdef PARITY_EN
    // Parity bit: 8'h07 -> 1, 8'h03 -> 0
    for (int w = 0; w < 2; w++) begin
      s_data_a = (w == 0) ? 8'h07 : 8'h03;
      s_valid_a = 1'b1;
      cnt = 0;
      rec = '0;
      for (int i = 1; i <= 50; i++) begin
        @(negedge clk);
        if (pad_t_a == 1'b0) begin
          cnt++;
          rec = {rec[126:0], pad_o_a};
        end
        s_valid_a = 1'b0;
      end
      check("parity bit", rec[5:2], (w == 0) ? 4'hF : 4'h0);
      check("parity burst length", cnt, A5_LEN);
    end
`endif

    // Reset in the middle of SHIFT releases the line at once
    s_data_a = 8'h5A;
    s_valid_a = 1'b1;
    @(negedge clk);
    s_valid_a = 1'b0;
    repeat (10) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid-burst reset pad_t", pad_t_a, 1'b1);
    check("mid-burst reset pad_o", pad_o_a, IDLE_LVL);
    check("mid-burst reset busy", busy_a, 1'b0);
    check("mid-burst reset s_ready", s_ready_a, 1'b0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("after reset s_ready", s_ready_a, 1'b1);
    check("after reset pad_t", pad_t_a, 1'b1);

    // Instance B: TURN_CYC=0, CLK_DIV=1, DATA_W=4, word 4'b0110
    s_data_b = 4'b0110;
    s_valid_b = 1'b1;
    cnt = 0;
    rec = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (pad_t_b == 1'b0) begin
        cnt++;
        rec = {rec[126:0], pad_o_b};
      end
      if (i == 2) check("B mid-burst s_ready", s_ready_b, 1'b0);
      if (i == B_BITS) check("B last-bit s_ready", s_ready_b, 1'b1);
      if (i == B_BITS + 1) check("B idle s_ready", s_ready_b, 1'b1);
      s_valid_b = 1'b0;
      s_data_b  = 4'b1001;
    end
    check("B burst length", cnt, B_BITS);
    check("B bit pattern", rec, B_PAT);
    check("B busy after", busy_b, 1'b0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
